mem_dp_be_init: RTL and testbench

MEM_DP_BE_INIT -- requirements
Module: mem_dp_be_init

---
 rtl/mem_dp_pkg.sv | 12 +
 rtl/mem_dp_init_ctrl.sv | 67 ++++++
 rtl/mem_dp_be_init.sv | 85 ++++++++
 tb/tb_mem_dp_be_init.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mem_dp_pkg.sv
// Shared types and default geometry for the byte-enable dual-port memory.
package mem_dp_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 4;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

endpackage

// File: rtl/mem_dp_init_ctrl.sv
// Init/idle controller: sweeps every address with zeros after reset or clr.
module mem_dp_init_ctrl
  import mem_dp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  output logic                  ready,
  output logic                  init_we,
  output logic [ADDR_WIDTH-1:0] init_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                state;
  state_e                state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [ADDR_WIDTH-1:0] init_cnt_nxt;

  // Next-state and sweep counter; clr restarts the sweep from either state
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    case (state)
      ST_INIT: begin
        if (clr) begin
          init_cnt_nxt = '0;
        end else if (init_cnt == LAST_ADDR) begin
          state_nxt    = ST_IDLE;
          init_cnt_nxt = '0;
        end else begin
          init_cnt_nxt = ADDR_WIDTH'(init_cnt + 1'b1);
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_nxt    = ST_INIT;
          init_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = ST_INIT;
        init_cnt_nxt = '0;
      end
    endcase
  end

  // State, counter and decoded strobes, all registered off the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      ready    <= 1'b0;
      init_we  <= 1'b1;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
      ready    <= (state_nxt == ST_IDLE);
      init_we  <= (state_nxt == ST_INIT);
    end
  end

  assign init_addr = init_cnt;

endmodule

// File: rtl/mem_dp_be_init.sv
// Byte-enable memory with one write and one read port, self-clearing sweep
// after reset/clr, write-first bypass and a registered read port.
module mem_dp_be_init
  import mem_dp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  output logic                    ready,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  wr_fire_c;
  logic                  rd_fire_c;
  logic [DATA_WIDTH-1:0] rd_word_c;

  mem_dp_init_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .ready    (ready),
    .init_we  (init_we),
    .init_addr(init_addr)
  );

  // Accesses only count in IDLE, and a clr in the same cycle cancels them
  assign wr_fire_c = ready & wr_en & ~clr;
  assign rd_fire_c = ready & rd_en & ~clr;

  // Write-first bypass: enabled lanes of a colliding write override the array
  always_comb begin
    rd_word_c = mem[rd_addr];
    for (int unsigned i = 0; i < BE_WIDTH; i++) begin
      if (wr_fire_c && (wr_addr == rd_addr) && wr_be[i]) begin
        rd_word_c[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  // Array update: zero sweep during init, byte-lane merge otherwise
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= '0;
    end else if (wr_fire_c) begin
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Read register; data holds when no read is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_fire_c;
      if (rd_fire_c) begin
        rd_data <= rd_word_c;
      end
    end
  end

endmodule

// File: tb/tb_mem_dp_be_init.sv
// Directed bench for mem_dp_be_init (32-bit words, 16 entries).
module tb_mem_dp_be_init;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic        rd_valid;
  logic [31:0] rd_data;

  int n_cmp = 0;
  int n_bad = 0;

  mem_dp_be_init #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .ready   (ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_be   (wr_be),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_valid(rd_valid),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All driving and sampling happens on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    check_eq({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check_eq({tag, "_data"}, rd_data, exp);
    tick();
    check_eq({tag, "_strobe_drop"}, 32'(rd_valid), 32'd0);
    check_eq({tag, "_hold"}, rd_data, exp);
  endtask

  // Sweep watch: ready must be low for edges 1..15 and high on edge 16
  task automatic watch_sweep(input string tag);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_eq($sformatf("%s_ready_e%0d", tag, k), 32'(ready), (k == 16) ? 32'd1 : 32'd0);
      check_eq($sformatf("%s_rdv_e%0d", tag, k), 32'(rd_valid), 32'd0);
    end
  endtask

  logic [31:0] bb_data [4];

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    tick(); tick();

    // Reset state
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rd_data", rd_data, 32'd0);

    // Release: ready exactly 16 edges later
    rst_n = 1'b1;
    watch_sweep("boot");

    // Every address reads zero, issued back-to-back
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; rd_addr = 4'(i);
      tick();
      check_eq($sformatf("zero_valid_%0d", i), 32'(rd_valid), 32'd1);
      check_eq($sformatf("zero_data_%0d", i), rd_data, 32'd0);
    end
    rd_en = 1'b0;
    tick();
    check_eq("zero_valid_end", 32'(rd_valid), 32'd0);

    // Byte-lane merge
    do_write(4'd3, 4'b1111, 32'hAABBCCDD);
    do_write(4'd3, 4'b0101, 32'h11223344);
    do_read("merge3", 4'd3, 32'hAA22CC44);

    // Same-cycle write/read collision returns write-first merge
    do_write(4'd5, 4'b1111, 32'hFFFFFFFF);
    wr_en = 1'b1; wr_addr = 4'd5; wr_be = 4'b0011; wr_data = 32'h12345678;
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check_eq("bypass_valid", 32'(rd_valid), 32'd1);
    check_eq("bypass_data", rd_data, 32'hFFFF5678);
    do_read("bypass_stored", 4'd5, 32'hFFFF5678);

    // Write with no lanes enabled is a no-op, collision read sees old data
    wr_en = 1'b1; wr_addr = 4'd5; wr_be = 4'b0000; wr_data = 32'h00000000;
    rd_en = 1'b1; rd_addr = 4'd5;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check_eq("be0_bypass", rd_data, 32'hFFFF5678);
    do_read("be0_stored", 4'd5, 32'hFFFF5678);

    // Back-to-back reads of four distinct words
    bb_data[0] = 32'h01020304; bb_data[1] = 32'h0A0B0C0D;
    bb_data[2] = 32'hCAFEF00D; bb_data[3] = 32'h80000001;
    for (int i = 0; i < 4; i++) do_write(4'(i), 4'b1111, bb_data[i]);
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; rd_addr = 4'(i);
      tick();
      check_eq($sformatf("b2b_valid_%0d", i), 32'(rd_valid), 32'd1);
      check_eq($sformatf("b2b_data_%0d", i), rd_data, bb_data[i]);
    end
    rd_en = 1'b0;
    tick();
    check_eq("b2b_valid_end", 32'(rd_valid), 32'd0);

    // clr together with a write and a read: both dropped, sweep clears all
    do_write(4'd7, 4'b1111, 32'h0BADF00D);
    clr = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd7; wr_be = 4'b1111; wr_data = 32'hDEADBEEF;
    rd_en = 1'b1; rd_addr = 4'd7;
    tick();
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    check_eq("clr_ready", 32'(ready), 32'd0);
    check_eq("clr_rdv", 32'(rd_valid), 32'd0);
    watch_sweep("clr");
    do_read("clr_addr7", 4'd7, 32'd0);
    do_read("clr_addr3", 4'd3, 32'd0);

    // Reset in the middle of a sweep (init_cnt == 9)
    do_write(4'd2, 4'b1111, 32'h5A5A5A5A);
    do_read("pre_rst", 4'd2, 32'h5A5A5A5A);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_ready", 32'(ready), 32'd0);
    check_eq("midrst_rdv", 32'(rd_valid), 32'd0);
    check_eq("midrst_rd_data", rd_data, 32'd0);
    tick();
    rst_n = 1'b1;
    rd_en = 1'b1; rd_addr = 4'd2;
    watch_sweep("midrst");
    rd_en = 1'b0;
    do_read("post_rst_addr2", 4'd2, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
